// File: rtl/xpu_mac_pkg.sv
// Shared xpu MAC definitions: frame-control encodings, response types, responder FSM states
// and the 14-byte-PSDU symbol-count helper used for CTS/ACK airtime.
package xpu_mac_pkg;

  localparam logic [1:0]  FC_TYPE_MGMT   = 2'b00;
  localparam logic [1:0]  FC_TYPE_CTRL   = 2'b01;
  localparam logic [1:0]  FC_TYPE_DATA   = 2'b10;
  localparam logic [3:0]  FC_SUBTYPE_RTS = 4'b1011;
  localparam logic [15:0] RTS_LEN        = 16'd20;

  localparam logic RESP_ACK = 1'b0;
  localparam logic RESP_CTS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_CHK_RA   = 3'd2,
    ST_WAIT_FCS = 3'd3,
    ST_SIFS     = 3'd4,
    ST_REQ      = 3'd5
  } resp_state_t;

  // OFDM symbols for a 14-byte PSDU: 16 service + 112 data + 6 tail = 134 bits.
  function automatic logic [2:0] n_sym_len14_pkt(input logic [7:0] rate);
    logic [2:0] n;
    n = 3'd1;
    if (rate[7]) begin
      case (rate[2:0])
        3'd0:    n = 3'd6;
        3'd1:    n = 3'd3;
        3'd2:    n = 3'd2;
        3'd3:    n = 3'd2;
        default: n = 3'd1;
      endcase
    end else begin
      case (rate[3:0])
        4'b1011: n = 3'd6;  // 6M
        4'b1111: n = 3'd4;  // 9M
        4'b1010: n = 3'd3;  // 12M
        4'b1110: n = 3'd2;  // 18M
        4'b1001: n = 3'd2;  // 24M
        default: n = 3'd1;  // 36M and above
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/sifs_resp_timer.sv
// Loadable microsecond down-counter that stops at zero; shared by the SIFS wait
// and the response-request timeout.
module sifs_resp_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sifs_resp_sched.sv
// SIFS response scheduler: owes an ACK (and a CTS when RESP_CTS_EN is defined) for a
// good unicast frame addressed to us, then requests the tx path after SIFS.
module sifs_resp_sched
  import xpu_mac_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH     = 8,
  parameter int unsigned RESP_TIMEOUT_US = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tsf_pulse_1M,
  input  logic        resp_enable,
  input  logic        pkt_header_valid_strobe,
  input  logic        pkt_header_valid,
  input  logic [7:0]  signal_rate,
  input  logic [15:0] signal_len,
  input  logic        FC_DI_valid,
  input  logic [1:0]  FC_type,
  input  logic [3:0]  FC_subtype,
  input  logic [15:0] duration,
  input  logic        addr1_valid,
  input  logic [47:0] addr1,
  input  logic        addr2_valid,
  input  logic [47:0] addr2,
  input  logic [47:0] self_mac_addr,
  input  logic        fcs_in_strobe,
  input  logic        fcs_valid,
  input  logic [6:0]  sifs_time,
  input  logic [6:0]  sifs_advance,
  input  logic [6:0]  preamble_sig_time,
  input  logic [4:0]  ofdm_symbol_time,
  input  logic        resp_ack,
  output logic        resp_req,
  output logic        resp_type,
  output logic [47:0] resp_ra,
  output logic [15:0] resp_duration,
  output logic [7:0]  resp_rate,
  output logic        resp_busy
);

  resp_state_t state, state_nxt;

  logic                   tmr_load;
  logic [TIMER_WIDTH-1:0] tmr_val;
  logic                   tmr_zero;
  logic                   elig_ack, elig_cts, elig;
  logic                   ra_match;
  logic [6:0]             sifs_load;
  logic [15:0]            resp_dur_nxt;

  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LOAD = TIMER_WIDTH'(RESP_TIMEOUT_US);

  sifs_resp_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tsf_pulse_1M),
    .zero     (tmr_zero)
  );

  assign elig_ack  = (FC_type == FC_TYPE_MGMT) || (FC_type == FC_TYPE_DATA);
  assign ra_match  = (addr1 == self_mac_addr) && !addr1[0];
  assign sifs_load = (sifs_time > sifs_advance) ? (sifs_time - sifs_advance) : 7'd0;

`ifdef RESP_CTS_EN
  logic        type_q;
  logic [15:0] dur_q;
  logic [15:0] len_q;
  logic [15:0] ctsack_time, cts_sub, cts_dur;

  assign elig_cts = (FC_type == FC_TYPE_CTRL) && (FC_subtype == FC_SUBTYPE_RTS) && (len_q == RTS_LEN);

  always_comb begin
    ctsack_time = 16'(preamble_sig_time)
                + 16'(ofdm_symbol_time) * 16'(n_sym_len14_pkt(resp_rate));
    cts_sub     = 16'(sifs_time) + ctsack_time;
    cts_dur     = '0;
    if (!dur_q[15] && ({1'b0, dur_q[14:0]} > cts_sub))
      cts_dur = {1'b0, dur_q[14:0]} - cts_sub;
  end

  assign resp_dur_nxt = type_q ? cts_dur : 16'd0;
  assign resp_type    = type_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      type_q <= RESP_ACK;
      dur_q  <= '0;
      len_q  <= '0;
    end else if (pkt_header_valid_strobe) begin
      len_q  <= signal_len;
    end else if ((state == ST_HDR) && FC_DI_valid) begin
      type_q <= elig_cts ? RESP_CTS : RESP_ACK;
      dur_q  <= duration;
    end
  end
`else
  logic unused_cfg;

  assign elig_cts     = 1'b0;
  assign resp_dur_nxt = 16'd0;
  assign resp_type    = RESP_ACK;
  assign unused_cfg   = ^{duration, FC_subtype, signal_len, preamble_sig_time, ofdm_symbol_time};
`endif

  assign elig = elig_ack || elig_cts;

  // A new header strobe preempts everything, including an outstanding request.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    if (pkt_header_valid_strobe) begin
      state_nxt = (pkt_header_valid && resp_enable) ? ST_HDR : ST_IDLE;
    end else begin
      case (state)
        ST_HDR: begin
          if (FC_DI_valid)
            state_nxt = elig ? ST_CHK_RA : ST_IDLE;
        end
        ST_CHK_RA: begin
          if (addr1_valid && addr2_valid)
            state_nxt = ra_match ? ST_WAIT_FCS : ST_IDLE;
        end
        ST_WAIT_FCS: begin
          if (fcs_in_strobe) begin
            if (!fcs_valid) begin
              state_nxt = ST_IDLE;
            end else if (sifs_load == 7'd0) begin
              state_nxt = ST_REQ;
              tmr_load  = 1'b1;
              tmr_val   = TIMEOUT_LOAD;
            end else begin
              state_nxt = ST_SIFS;
              tmr_load  = 1'b1;
              tmr_val   = TIMER_WIDTH'(sifs_load);
            end
          end
        end
        ST_SIFS: begin
          if (tmr_zero) begin
            state_nxt = ST_REQ;
            tmr_load  = 1'b1;
            tmr_val   = TIMEOUT_LOAD;
          end
        end
        ST_REQ: begin
          if (resp_ack || tmr_zero)
            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      resp_ra       <= '0;
      resp_duration <= '0;
      resp_rate     <= '0;
    end else begin
      state <= state_nxt;
      if (pkt_header_valid_strobe)
        resp_rate <= signal_rate;
      else if ((state == ST_CHK_RA) && addr1_valid && addr2_valid && ra_match)
        resp_ra <= addr2;
      else if ((state == ST_WAIT_FCS) && fcs_in_strobe && fcs_valid)
        resp_duration <= resp_dur_nxt;
    end
  end

  assign resp_req  = (state == ST_REQ) && !resp_ack && !pkt_header_valid_strobe;
  assign resp_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sifs_resp_sched.sv
// Directed bench for sifs_resp_sched; expectations are hand-computed.
// RESP_CTS_EN selects which RTS outcome is expected.
module tb_sifs_resp_sched;

  logic        clk = 1'b0;
  logic        rst, tsf_pulse_1M, resp_enable;
  logic        pkt_header_valid_strobe, pkt_header_valid;
  logic [7:0]  signal_rate;
  logic [15:0] signal_len;
  logic        FC_DI_valid;
  logic [1:0]  FC_type;
  logic [3:0]  FC_subtype;
  logic [15:0] duration;
  logic        addr1_valid, addr2_valid;
  logic [47:0] addr1, addr2, self_mac_addr;
  logic        fcs_in_strobe, fcs_valid;
  logic [6:0]  sifs_time, sifs_advance, preamble_sig_time;
  logic [4:0]  ofdm_symbol_time;
  logic        resp_ack;
  logic        resp_req, resp_type, resp_busy;
  logic [47:0] resp_ra;
  logic [15:0] resp_duration;
  logic [7:0]  resp_rate;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses;

  localparam logic [47:0] SELF  = 48'h6655_4433_2210;
  localparam logic [47:0] PEER  = 48'hA1A2_A3A4_A5A6;
  localparam logic [47:0] OTHER = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  sifs_resp_sched #(
    .TIMER_WIDTH     (8),
    .RESP_TIMEOUT_US (16)
  ) dut (
    .clk (clk), .rst (rst), .tsf_pulse_1M (tsf_pulse_1M), .resp_enable (resp_enable),
    .pkt_header_valid_strobe (pkt_header_valid_strobe), .pkt_header_valid (pkt_header_valid),
    .signal_rate (signal_rate), .signal_len (signal_len), .FC_DI_valid (FC_DI_valid),
    .FC_type (FC_type), .FC_subtype (FC_subtype), .duration (duration),
    .addr1_valid (addr1_valid), .addr1 (addr1), .addr2_valid (addr2_valid), .addr2 (addr2),
    .self_mac_addr (self_mac_addr), .fcs_in_strobe (fcs_in_strobe), .fcs_valid (fcs_valid),
    .sifs_time (sifs_time), .sifs_advance (sifs_advance), .preamble_sig_time (preamble_sig_time),
    .ofdm_symbol_time (ofdm_symbol_time), .resp_ack (resp_ack), .resp_req (resp_req),
    .resp_type (resp_type), .resp_ra (resp_ra), .resp_duration (resp_duration),
    .resp_rate (resp_rate), .resp_busy (resp_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      tsf_pulse_1M = 1'b1;
      step(1);
      tsf_pulse_1M = 1'b0;
      step(2);
    end
  endtask

  task automatic send_frame(input logic [1:0] ty, input logic [3:0] st, input logic [15:0] len,
                            input logic [15:0] dur, input logic [47:0] a1, input logic fcs_ok);
    pkt_header_valid_strobe = 1'b1; pkt_header_valid = 1'b1;
    signal_rate = 8'h0B; signal_len = len;
    step(1);
    pkt_header_valid_strobe = 1'b0;
    FC_DI_valid = 1'b1; FC_type = ty; FC_subtype = st; duration = dur;
    step(1);
    FC_DI_valid = 1'b0;
    addr1_valid = 1'b1; addr2_valid = 1'b1; addr1 = a1; addr2 = PEER;
    step(1);
    addr1_valid = 1'b0; addr2_valid = 1'b0;
    fcs_in_strobe = 1'b1; fcs_valid = fcs_ok;
    step(1);
    fcs_in_strobe = 1'b0; fcs_valid = 1'b0;
  endtask

  task automatic do_ack();
    resp_ack = 1'b1;
    #1;
    check("req_drop_on_ack", resp_req, 1'b0);
    step(1);
    resp_ack = 1'b0;
    check("idle_after_ack", resp_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; tsf_pulse_1M = 1'b0; resp_enable = 1'b1;
    pkt_header_valid_strobe = 1'b0; pkt_header_valid = 1'b0;
    signal_rate = '0; signal_len = '0; FC_DI_valid = 1'b0; FC_type = '0; FC_subtype = '0;
    duration = '0; addr1_valid = 1'b0; addr2_valid = 1'b0; addr1 = '0; addr2 = '0;
    self_mac_addr = SELF; fcs_in_strobe = 1'b0; fcs_valid = 1'b0;
    sifs_time = 7'd16; sifs_advance = 7'd2; preamble_sig_time = 7'd20; ofdm_symbol_time = 5'd4;
    resp_ack = 1'b0;
    step(2);
    check("rst_req", resp_req, 1'b0);
    check("rst_busy", resp_busy, 1'b0);
    check("rst_ra", resp_ra, 48'h0);
    check("rst_dur", resp_duration, 16'h0);
    rst = 1'b0;
    step(1);

    // Data frame to self: 14 us SIFS wait then ACK request.
    send_frame(2'b10, 4'b0000, 16'd100, 16'd44, SELF, 1'b1);
    check("t1_busy_sifs", resp_busy, 1'b1);
    tick(13);
    check("t1_req_early", resp_req, 1'b0);
    tick(1);
    check("t1_req", resp_req, 1'b1);
    check("t1_type", resp_type, 1'b0);
    check("t1_dur", resp_duration, 16'd0);
    check("t1_ra", resp_ra, PEER);
    check("t1_rate", resp_rate, 8'h0B);
    do_ack();

    // Rejections: bad FCS, foreign RA, broadcast RA.
    send_frame(2'b10, 4'b0000, 16'd100, 16'd44, SELF, 1'b0);
    check("t2_fcs_busy", resp_busy, 1'b0);
    tick(20);
    check("t2_fcs_req", resp_req, 1'b0);
    send_frame(2'b10, 4'b0000, 16'd100, 16'd44, OTHER, 1'b1);
    check("t2_ra_busy", resp_busy, 1'b0);
    tick(20);
    check("t2_ra_req", resp_req, 1'b0);
    send_frame(2'b10, 4'b0000, 16'd100, 16'd44, BCAST, 1'b1);
    check("t2_bc_busy", resp_busy, 1'b0);

    // RTS: 300 - 16 - (20 + 4*6) = 240.
    send_frame(2'b01, 4'b1011, 16'd20, 16'd300, SELF, 1'b1);
`ifdef RESP_CTS_EN
    tick(14);
    check("t3_req", resp_req, 1'b1);
    check("t3_type", resp_type, 1'b1);
    check("t3_dur", resp_duration, 16'd240);
    do_ack();
    send_frame(2'b01, 4'b1011, 16'd20, 16'd50, SELF, 1'b1);
    tick(14);
    check("t3_sat_dur", resp_duration, 16'd0);
    do_ack();
    send_frame(2'b01, 4'b1011, 16'd20, 16'h812C, SELF, 1'b1);
    tick(14);
    check("t3_b15_dur", resp_duration, 16'd0);
    do_ack();
`else
    check("t3_no_cts_busy", resp_busy, 1'b0);
    tick(20);
    check("t3_no_cts_req", resp_req, 1'b0);
`endif

    // Timeout: request held for exactly 16 us.
    send_frame(2'b00, 4'b0000, 16'd30, 16'd0, SELF, 1'b1);
    tick(14);
    check("t4_req", resp_req, 1'b1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (!resp_req) break;
      tick(1);
      pulses++;
    end
    check("t4_pulses", pulses, 16);
    check("t4_idle", resp_busy, 1'b0);

    // Zero SIFS load goes straight to REQ.
    sifs_time = 7'd2; sifs_advance = 7'd5;
    send_frame(2'b10, 4'b0000, 16'd100, 16'd0, SELF, 1'b1);
    check("zero_load_req", resp_req, 1'b1);
    do_ack();
    sifs_time = 7'd16; sifs_advance = 7'd2;

    // Header strobe during SIFS and during REQ.
    send_frame(2'b10, 4'b0000, 16'd100, 16'd0, SELF, 1'b1);
    tick(5);
    pkt_header_valid_strobe = 1'b1; pkt_header_valid = 1'b1;
    step(1);
    pkt_header_valid_strobe = 1'b0;
    check("t5_sifs_hdr_busy", resp_busy, 1'b1);
    tick(20);
    check("t5_sifs_req", resp_req, 1'b0);
    pkt_header_valid_strobe = 1'b1; pkt_header_valid = 1'b0;
    step(1);
    pkt_header_valid_strobe = 1'b0;
    check("t5_bad_hdr_idle", resp_busy, 1'b0);
    send_frame(2'b10, 4'b0000, 16'd100, 16'd0, SELF, 1'b1);
    tick(14);
    check("t5_req", resp_req, 1'b1);
    pkt_header_valid_strobe = 1'b1; pkt_header_valid = 1'b1;
    #1;
    check("t5_req_drop", resp_req, 1'b0);
    step(1);
    pkt_header_valid_strobe = 1'b0;
    check("t5_req_hdr_busy", resp_busy, 1'b1);
    check("t5_req_after", resp_req, 1'b0);
    pkt_header_valid_strobe = 1'b1; pkt_header_valid = 1'b0;
    step(1);
    pkt_header_valid_strobe = 1'b0;

    // Reset mid-SIFS, then responses disabled.
    send_frame(2'b10, 4'b0000, 16'd100, 16'd0, SELF, 1'b1);
    tick(5);
    rst = 1'b1;
    step(1);
    check("t6_busy", resp_busy, 1'b0);
    check("t6_req", resp_req, 1'b0);
    check("t6_ra", resp_ra, 48'h0);
    check("t6_rate", resp_rate, 8'h0);
    check("t6_type", resp_type, 1'b0);
    rst = 1'b0;
    step(1);
    resp_enable = 1'b0;
    send_frame(2'b10, 4'b0000, 16'd100, 16'd0, SELF, 1'b1);
    check("t6_dis_busy", resp_busy, 1'b0);
    tick(20);
    check("t6_dis_req", resp_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
